tmds_encoder_multi: RTL and testbench

- Pipelined, multi-channel TMDS encoder producing 10-bit symbols for the HDMI serialiser.
- Per channel:
  - transition minimisation (XOR/XNOR choice);
  - running-disparity DC balancing;
  - control-period symbols;
  - video guard bands;
  - TERC4 data-island symbols.
- Sits between the video/packet mux and the 10:1 serialisers.
- All channels share one mode and one pipeline.

---
 rtl/tmds_pkg.sv | 30 +++
 rtl/tmds_channel_encoder.sv | 128 ++++++++++++
 rtl/tmds_encoder_multi.sv | 56 +++++
 tb/tb_tmds_encoder_multi.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS symbol tables, mode encoding and a popcount helper for the encoder slice.
package tmds_pkg;

    typedef enum logic [1:0] {
        CONTROL = 2'd0,
        VIDEO   = 2'd1,
        VGUARD  = 2'd2,
        TERC4   = 2'd3
    } tmds_mode_t;

    localparam logic [9:0] CTRL_CODE [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    localparam logic [9:0] GUARD_A = 10'h2CC;
    localparam logic [9:0] GUARD_B = 10'h133;

    localparam logic [9:0] TERC4_CODE [16] = '{
        10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
        10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3
    };

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// One TMDS lane: stage 1 builds q_m, stage 2 picks the symbol and updates running disparity.
// Fixed 2-cycle latency, never stalls; the counter register doubles as the debug output.
module tmds_channel_encoder
    import tmds_pkg::*;
#(
    parameter int CH_IDX = 0,
    parameter int CNT_W  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  tmds_mode_t              mode,
    input  logic [7:0]              data,
    input  logic [1:0]              ctrl,
    input  logic [3:0]              terc4,
    output logic [9:0]              tmds,
    output logic signed [CNT_W-1:0] disparity
);

    localparam logic signed [CNT_W-1:0] ZERO  = '0;
    localparam logic signed [CNT_W-1:0] TWO   = CNT_W'(2);
    localparam logic signed [CNT_W-1:0] EIGHT = CNT_W'(8);
    // Lanes 1, 4, 7... carry the inverted guard pattern.
    localparam logic [9:0] GUARD_SYM = (CH_IDX % 3 == 1) ? GUARD_B : GUARD_A;

    logic [3:0] n1d;
    logic       use_xnor;
    logic [8:0] qm;

    always_comb begin
        n1d      = popcount8(data);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data[0]);
        qm       = '0;
        qm[0]    = data[0];
        for (int k = 1; k < 8; k++) begin
            qm[k] = use_xnor ? ~(qm[k-1] ^ data[k]) : (qm[k-1] ^ data[k]);
        end
        qm[8] = ~use_xnor;
    end

    logic [8:0] s1_qm;
    tmds_mode_t s1_mode;
    logic [1:0] s1_ctrl;
    logic [3:0] s1_terc4;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_qm    <= '0;
            s1_mode  <= CONTROL;
            s1_ctrl  <= '0;
            s1_terc4 <= '0;
        end else begin
            s1_qm    <= qm;
            s1_mode  <= mode;
            s1_ctrl  <= ctrl;
            s1_terc4 <= terc4;
        end
    end

    logic                    q8;
    logic [7:0]              q;
    logic [3:0]              n1;
    logic signed [CNT_W-1:0] n1_ext;
    logic signed [CNT_W-1:0] bal;
    logic                    cnt_zero;
    logic                    cnt_pos;
    logic                    cnt_neg;
    logic                    bal_zero;
    logic                    bal_pos;
    logic                    bal_neg;
    logic [9:0]              vid_sym;
    logic signed [CNT_W-1:0] vid_cnt;
    logic [9:0]              sym_nxt;
    logic signed [CNT_W-1:0] cnt_nxt;

    always_comb begin
        q8     = s1_qm[8];
        q      = s1_qm[7:0];
        n1     = popcount8(q);
        n1_ext = {{(CNT_W-4){1'b0}}, n1};
        // n1 - n0 with n0 = 8 - n1; exact in CNT_W bits since the result is within +-8.
        bal    = n1_ext - (EIGHT - n1_ext);

        cnt_zero = (disparity == ZERO);
        cnt_neg  = disparity[CNT_W-1];
        cnt_pos  = !cnt_neg && !cnt_zero;
        bal_zero = (bal == ZERO);
        bal_neg  = bal[CNT_W-1];
        bal_pos  = !bal_neg && !bal_zero;

        if (cnt_zero || bal_zero) begin
            vid_sym = {~q8, q8, (q8 ? q : ~q)};
            vid_cnt = q8 ? (disparity + bal) : (disparity - bal);
        end else if ((cnt_pos && bal_pos) || (cnt_neg && bal_neg)) begin
            vid_sym = {1'b1, q8, ~q};
            vid_cnt = disparity - bal + (q8 ? TWO : ZERO);
        end else begin
            vid_sym = {1'b0, q8, q};
            vid_cnt = disparity + bal - (q8 ? ZERO : TWO);
        end
    end

    // Any non-video symbol restarts the disparity so the next video run begins balanced.
    always_comb begin
        sym_nxt = CTRL_CODE[s1_ctrl];
        cnt_nxt = ZERO;
        case (s1_mode)
            CONTROL: sym_nxt = CTRL_CODE[s1_ctrl];
            VIDEO: begin
                sym_nxt = vid_sym;
                cnt_nxt = vid_cnt;
            end
            VGUARD:  sym_nxt = GUARD_SYM;
            TERC4:   sym_nxt = TERC4_CODE[s1_terc4];
            default: sym_nxt = CTRL_CODE[s1_ctrl];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmds      <= '0;
            disparity <= ZERO;
        end else begin
            tmds      <= sym_nxt;
            disparity <= cnt_nxt;
        end
    end

endmodule

// File: rtl/tmds_encoder_multi.sv
// NUM_CH parallel TMDS lanes sharing one mode and a 2-cycle pipeline; valid rides alongside.
// Accepts a symbol every cycle, no backpressure.
module tmds_encoder_multi
    import tmds_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 5
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [1:0]                mode_in,
    input  logic [NUM_CH*8-1:0]       data_in,
    input  logic [NUM_CH*2-1:0]       ctrl_in,
    input  logic [NUM_CH*4-1:0]       terc4_in,
    input  logic                      valid_in,
    output logic [NUM_CH*10-1:0]      tmds_out,
    output logic                      valid_out,
    output logic [NUM_CH*CNT_W-1:0]   disparity_out
);

    tmds_mode_t mode;
    logic [1:0] valid_pipe;

    assign mode = tmds_mode_t'(mode_in);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe <= {valid_pipe[0], valid_in};
        end
    end

    assign valid_out = valid_pipe[1];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic signed [CNT_W-1:0] disp;

        tmds_channel_encoder #(
            .CH_IDX (i),
            .CNT_W  (CNT_W)
        ) u_enc (
            .clk       (clk_in),
            .rst       (rst_in),
            .mode      (mode),
            .data      (data_in[i*8 +: 8]),
            .ctrl      (ctrl_in[i*2 +: 2]),
            .terc4     (terc4_in[i*4 +: 4]),
            .tmds      (tmds_out[i*10 +: 10]),
            .disparity (disp)
        );

        assign disparity_out[i*CNT_W +: CNT_W] = disp;
    end

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Randomized bench for tmds_encoder_multi against a symbol-level reference model.
module tb_tmds_encoder_multi;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 5;

    logic                    clk_in = 1'b0;
    logic                    rst_in;
    logic [1:0]              mode_in;
    logic [NUM_CH*8-1:0]     data_in;
    logic [NUM_CH*2-1:0]     ctrl_in;
    logic [NUM_CH*4-1:0]     terc4_in;
    logic                    valid_in;
    logic [NUM_CH*10-1:0]    tmds_out;
    logic                    valid_out;
    logic [NUM_CH*CNT_W-1:0] disparity_out;

    tmds_encoder_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .mode_in       (mode_in),
        .data_in       (data_in),
        .ctrl_in       (ctrl_in),
        .terc4_in      (terc4_in),
        .valid_in      (valid_in),
        .tmds_out      (tmds_out),
        .valid_out     (valid_out),
        .disparity_out (disparity_out)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_bad = 0;

    logic [9:0] ctrl_tab [4]  = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    logic [9:0] terc_tab [16] = '{
        10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
        10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3
    };

    // Model state: the inputs last sampled, and the symbols/counters currently shown.
    logic [1:0]              m1_mode;
    logic [7:0]              m1_data [NUM_CH];
    logic [1:0]              m1_ctrl [NUM_CH];
    logic [3:0]              m1_terc [NUM_CH];
    logic                    m1_valid;
    logic [9:0]              m_sym   [NUM_CH];
    int                      m_cnt   [NUM_CH];
    logic                    m_valid;
    logic [NUM_CH*10-1:0]    exp_tmds;
    logic [NUM_CH*CNT_W-1:0] exp_disp;

    function automatic int ones(input logic [9:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 10; i++) n = n + (v[i] ? 1 : 0);
        return n;
    endfunction

    function automatic logic [9:0] video_sym(input logic [7:0] d, input int cnt);
        int         n1d;
        int         n1;
        int         n0;
        logic       xn;
        logic       q8;
        logic [7:0] qm;
        n1d   = ones({2'b00, d});
        xn    = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm    = '0;
        qm[0] = d[0];
        for (int k = 1; k < 8; k++) qm[k] = xn ? ~(qm[k-1] ^ d[k]) : (qm[k-1] ^ d[k]);
        q8 = !xn;
        n1 = ones({2'b00, qm});
        n0 = 8 - n1;
        if (cnt == 0 || n1 == n0) return {~q8, q8, (q8 ? qm : ~qm)};
        if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) return {1'b1, q8, ~qm};
        return {1'b0, q8, qm};
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] d;
        q    = s[9] ? ~s[7:0] : s[7:0];
        d    = '0;
        d[0] = q[0];
        for (int k = 1; k < 8; k++) d[k] = s[8] ? (q[k] ^ q[k-1]) : ~(q[k] ^ q[k-1]);
        return d;
    endfunction

    // Advance one clock: update the model from what the DUT samples, then settle.
    task automatic tick();
        @(posedge clk_in);
        if (rst_in) begin
            m1_mode  = '0;
            m1_valid = 1'b0;
            m_valid  = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                m1_data[c] = '0; m1_ctrl[c] = '0; m1_terc[c] = '0;
                m_sym[c]   = '0; m_cnt[c]   = 0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                case (m1_mode)
                    2'd0: begin m_sym[c] = ctrl_tab[m1_ctrl[c]]; m_cnt[c] = 0; end
                    2'd1: begin
                        m_sym[c] = video_sym(m1_data[c], m_cnt[c]);
                        // The counter tracks the ones-minus-zeros of every emitted symbol.
                        m_cnt[c] = m_cnt[c] + 2 * ones(m_sym[c]) - 10;
                    end
                    2'd2: begin m_sym[c] = (c % 3 == 1) ? 10'h133 : 10'h2CC; m_cnt[c] = 0; end
                    default: begin m_sym[c] = terc_tab[m1_terc[c]]; m_cnt[c] = 0; end
                endcase
            end
            m_valid  = m1_valid;
            m1_mode  = mode_in;
            m1_valid = valid_in;
            for (int c = 0; c < NUM_CH; c++) begin
                m1_data[c] = data_in[c*8 +: 8];
                m1_ctrl[c] = ctrl_in[c*2 +: 2];
                m1_terc[c] = terc4_in[c*4 +: 4];
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            exp_tmds[c*10 +: 10]      = m_sym[c];
            exp_disp[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; mode_in = 2'd1; valid_in = 1'b1;
        data_in = '1; ctrl_in = '1; terc4_in = '1;
        tick();
        tick();
        n_vec++;
        if (tmds_out !== '0) begin
            n_bad++; $display("FAIL reset_tmds: got %h expected 0", tmds_out);
        end
        n_vec++;
        if (valid_out !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid: got %b expected 0", valid_out);
        end
        n_vec++;
        if (disparity_out !== '0) begin
            n_bad++; $display("FAIL reset_disp: got %h expected 0", disparity_out);
        end
        rst_in = 1'b0;
    endtask

    task automatic test_video_zero();
        mode_in = 2'd1; data_in = '0; ctrl_in = '0; terc4_in = '0; valid_in = 1'b1;
        tick();
        tick();
        n_vec++;
        if (tmds_out[9:0] !== 10'h100 || disparity_out[4:0] !== 5'h18) begin
            n_bad++;
            $display("FAIL zero_first: got sym %h cnt %h expected 100 / 18", tmds_out[9:0], disparity_out[4:0]);
        end
        n_vec++;
        if (valid_out !== 1'b1) begin
            n_bad++; $display("FAIL zero_valid1: got %b expected 1", valid_out);
        end
        mode_in = 2'd0; valid_in = 1'b0;
        tick();
        n_vec++;
        if (tmds_out[9:0] !== 10'h3FF || disparity_out[4:0] !== 5'h02) begin
            n_bad++;
            $display("FAIL zero_second: got sym %h cnt %h expected 3ff / 02", tmds_out[9:0], disparity_out[4:0]);
        end
        tick();
        n_vec++;
        if (valid_out !== 1'b0 || tmds_out !== exp_tmds) begin
            n_bad++;
            $display("FAIL zero_tail: got valid %b sym %h expected 0 / %h", valid_out, tmds_out, exp_tmds);
        end
    endtask

    task automatic test_control();
        mode_in = 2'd0; ctrl_in = 6'b11_01_00; valid_in = 1'b1;
        tick();
        tick();
        n_vec++;
        if (tmds_out !== {10'h2AB, 10'h0AB, 10'h354} || disparity_out !== '0) begin
            n_bad++;
            $display("FAIL control: got %h cnt %h expected 2ab0ab354 / 0", tmds_out, disparity_out);
        end
    endtask

    task automatic test_vguard();
        mode_in = 2'd2;
        tick();
        tick();
        n_vec++;
        if (tmds_out !== {10'h2CC, 10'h133, 10'h2CC} || disparity_out !== '0) begin
            n_bad++;
            $display("FAIL vguard: got %h cnt %h expected 2cc1332cc / 0", tmds_out, disparity_out);
        end
    endtask

    task automatic test_terc4();
        mode_in = 2'd3;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) terc4_in = {8'($urandom), 4'(i)};
            tick();
            if (i > 0) begin
                n_vec++;
                if (tmds_out[9:0] !== terc_tab[i-1] || disparity_out[4:0] !== 5'h00) begin
                    n_bad++;
                    $display("FAIL terc4_%0d: got %h cnt %h expected %h / 0", i - 1, tmds_out[9:0], disparity_out[4:0], terc_tab[i-1]);
                end
                n_vec++;
                if (tmds_out !== exp_tmds) begin
                    n_bad++; $display("FAIL terc4_all: got %h expected %h", tmds_out, exp_tmds);
                end
            end
        end
    endtask

    task automatic test_random_video();
        logic [NUM_CH*8-1:0] last_data;
        logic signed [CNT_W-1:0] dv;
        last_data = '0;
        mode_in = 2'd1;
        for (int i = 0; i < 3400; i++) begin
            data_in  = NUM_CH*8'($urandom);
            valid_in = 1'($urandom_range(0, 1));
            tick();
            n_vec++;
            if (tmds_out !== exp_tmds || disparity_out !== exp_disp || valid_out !== m_valid) begin
                n_bad++;
                $display("FAIL video_%0d: got %h/%h/%b expected %h/%h/%b", i, tmds_out, disparity_out, valid_out, exp_tmds, exp_disp, m_valid);
            end
            if (i > 0) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    n_vec++;
                    if (decode(tmds_out[c*10 +: 10]) !== last_data[c*8 +: 8]) begin
                        n_bad++;
                        $display("FAIL decode_%0d_ch%0d: got %h expected %h", i, c, decode(tmds_out[c*10 +: 10]), last_data[c*8 +: 8]);
                    end
                    dv = disparity_out[c*CNT_W +: CNT_W];
                    n_vec++;
                    if (dv > 10 || dv < -10) begin
                        n_bad++; $display("FAIL cnt_bound_%0d_ch%0d: got %0d expected |cnt|<=10", i, c, dv);
                    end
                end
            end
            last_data = data_in;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 600; i++) begin
            mode_in  = 2'($urandom);
            data_in  = NUM_CH*8'($urandom);
            ctrl_in  = NUM_CH*2'($urandom);
            terc4_in = NUM_CH*4'($urandom);
            valid_in = 1'($urandom_range(0, 1));
            tick();
            n_vec++;
            if (tmds_out !== exp_tmds || disparity_out !== exp_disp || valid_out !== m_valid) begin
                n_bad++;
                $display("FAIL mixed_%0d: got %h/%h/%b expected %h/%h/%b", i, tmds_out, disparity_out, valid_out, exp_tmds, exp_disp, m_valid);
            end
        end
    endtask

    task automatic test_ctrl_restart();
        ctrl_in = '0; data_in = '0; valid_in = 1'b1;
        mode_in = 2'd0; tick();
        mode_in = 2'd1; tick();
        tick();
        mode_in = 2'd0; tick();
        n_vec++;
        if (disparity_out[4:0] !== 5'h02) begin
            n_bad++; $display("FAIL restart_pre: got cnt %h expected 02", disparity_out[4:0]);
        end
        mode_in = 2'd1; tick();
        mode_in = 2'd0; tick();
        n_vec++;
        if (tmds_out[9:0] !== 10'h100 || disparity_out[4:0] !== 5'h18) begin
            n_bad++;
            $display("FAIL restart_post: got sym %h cnt %h expected 100 / 18", tmds_out[9:0], disparity_out[4:0]);
        end
        n_vec++;
        if (tmds_out !== exp_tmds || disparity_out !== exp_disp) begin
            n_bad++; $display("FAIL restart_all: got %h/%h expected %h/%h", tmds_out, disparity_out, exp_tmds, exp_disp);
        end
    endtask

    task automatic test_mid_reset();
        mode_in = 2'd1; valid_in = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 20 || i == 21) rst_in = 1'b1;
            else rst_in = 1'b0;
            data_in = NUM_CH*8'($urandom);
            tick();
            if (i == 20 || i == 21) begin
                n_vec++;
                if (tmds_out !== '0 || disparity_out !== '0 || valid_out !== 1'b0) begin
                    n_bad++;
                    $display("FAIL midreset_%0d: got %h/%h/%b expected 0/0/0", i, tmds_out, disparity_out, valid_out);
                end
            end else if (i == 22) begin
                n_vec++;
                if (valid_out !== 1'b0 || disparity_out !== '0) begin
                    n_bad++; $display("FAIL midreset_flush: got valid %b cnt %h expected 0 / 0", valid_out, disparity_out);
                end
            end
            n_vec++;
            if (tmds_out !== exp_tmds || disparity_out !== exp_disp || valid_out !== m_valid) begin
                n_bad++;
                $display("FAIL midreset_run_%0d: got %h/%h/%b expected %h/%h/%b", i, tmds_out, disparity_out, valid_out, exp_tmds, exp_disp, m_valid);
            end
        end
        rst_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_video_zero();
        test_control();
        test_vguard();
        test_terc4();
        test_random_video();
        test_back_to_back();
        test_ctrl_restart();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
